// File: rtl/steer_en_pkg.sv
// Shared types and default constants for the Segway steering-enable controller.
package steer_en_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_e;

  localparam int unsigned MIN_RIDER_WT_DEF = 32'h200;
  localparam int unsigned SETTLE_CNT_DEF   = 32'd65_000_000;
  localparam int unsigned FAST_CNT_DEF     = 32'd32_768;

endpackage

// File: rtl/steer_en_tmr.sv
// Settle timer: counts while enabled and flags when the selected limit is reached.
module steer_en_tmr #(
  parameter int unsigned TMR_W      = 26,
  parameter int unsigned SETTLE_CNT = 32'd65_000_000,
  parameter int unsigned FAST_CNT   = 32'd32_768
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_fast_sim,
  output logic o_tmr_full
);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CNT - 1);
  localparam logic [TMR_W-1:0] FAST_LAST   = TMR_W'(FAST_CNT - 1);

  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if (i_clr) begin
      r_tmr <= '0;
    end else if (i_inc) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // Greater-or-equal so a mid-count switch to a shorter limit fires at once.
  assign w_last     = i_fast_sim ? FAST_LAST : SETTLE_LAST;
  assign o_tmr_full = (r_tmr >= w_last);

endmodule

// File: rtl/steer_en_param.sv
// Steering-enable controller: load latch, balance arithmetic, rider-off debounce and FSM.
module steer_en_param
  import steer_en_pkg::*;
#(
  parameter int unsigned LD_W         = 12,
  parameter int unsigned MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter int unsigned EN_SHIFT     = 2,
  parameter int unsigned DIS_SHIFT    = 4,
  parameter int unsigned TMR_W        = 26,
  parameter int unsigned SETTLE_CNT   = SETTLE_CNT_DEF,
  parameter int unsigned FAST_CNT     = FAST_CNT_DEF,
  parameter int unsigned OFF_SAMPLES  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pwr_up,
  input  logic            i_fast_sim,
  input  logic            i_ld_vld,
  input  logic [LD_W-1:0] i_lft_ld,
  input  logic [LD_W-1:0] i_rght_ld,
  output logic            o_en_steer,
  output logic            o_rider_off,
  output logic [1:0]      o_steer_state
);

  localparam int unsigned SUM_W = LD_W + 1;
  localparam int unsigned OFF_W = $clog2(OFF_SAMPLES + 1);
  localparam logic [SUM_W-1:0] MIN_WT  = SUM_W'(MIN_RIDER_WT);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(OFF_SAMPLES);

  logic [LD_W-1:0]  r_lft;
  logic [LD_W-1:0]  r_rght;
  logic [OFF_W-1:0] r_off_cnt;
  logic             r_rider_off;
  steer_state_e     r_state;
  logic             r_en_steer;

  logic [SUM_W-1:0] w_sum;
  logic [LD_W-1:0]  w_diff;
  logic             w_sum_ok;
  logic             w_in_en_band;
  logic             w_out_dis_band;
  logic [SUM_W-1:0] w_new_sum;
  logic             w_new_low;
  logic [OFF_W-1:0] w_off_cnt_nxt;
  logic             w_tmr_clr;
  logic             w_tmr_inc;
  logic             w_tmr_full;

  assign w_sum          = {1'b0, r_lft} + {1'b0, r_rght};
  assign w_diff         = (r_lft >= r_rght) ? (r_lft - r_rght) : (r_rght - r_lft);
  assign w_sum_ok       = (w_sum >= MIN_WT);
  assign w_in_en_band   = ({1'b0, w_diff} <= (w_sum >> EN_SHIFT));
  assign w_out_dis_band = ({1'b0, w_diff} > (w_sum - (w_sum >> DIS_SHIFT)));

  // Debounce looks at the incoming sample so rider_off clears on the latch edge.
  assign w_new_sum = {1'b0, i_lft_ld} + {1'b0, i_rght_ld};
  assign w_new_low = (w_new_sum < MIN_WT);

  always_comb begin
    w_off_cnt_nxt = r_off_cnt;
    if (!w_new_low) begin
      w_off_cnt_nxt = '0;
    end else if (r_off_cnt != OFF_MAX) begin
      w_off_cnt_nxt = r_off_cnt + OFF_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lft       <= '0;
      r_rght      <= '0;
      r_off_cnt   <= '0;
      r_rider_off <= 1'b1;
    end else if (i_ld_vld) begin
      r_lft       <= i_lft_ld;
      r_rght      <= i_rght_ld;
      r_off_cnt   <= w_off_cnt_nxt;
      r_rider_off <= (w_off_cnt_nxt == OFF_MAX);
    end
  end

  // Timer only runs in WAIT, so every WAIT entry starts from zero.
  assign w_tmr_clr = (r_state != WAIT) || !w_in_en_band;
  assign w_tmr_inc = (r_state == WAIT);

  steer_en_tmr #(
    .TMR_W      (TMR_W),
    .SETTLE_CNT (SETTLE_CNT),
    .FAST_CNT   (FAST_CNT)
  ) u_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_tmr_clr),
    .i_inc      (w_tmr_inc),
    .i_fast_sim (i_fast_sim),
    .o_tmr_full (w_tmr_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_en_steer <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_pwr_up && w_sum_ok) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!i_pwr_up || !w_sum_ok) begin
            r_state <= IDLE;
          end else if (w_in_en_band && w_tmr_full) begin
            r_state    <= STEER;
            r_en_steer <= 1'b1;
          end
        end
        STEER: begin
          // A light sample alone is tolerated; only the debounced rider_off exits.
          if (!i_pwr_up || r_rider_off) begin
            r_state    <= IDLE;
            r_en_steer <= 1'b0;
          end else if (w_out_dis_band) begin
            r_state    <= WAIT;
            r_en_steer <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_en_steer <= 1'b0;
        end
      endcase
    end
  end

  assign o_en_steer    = r_en_steer;
  assign o_rider_off   = r_rider_off;
  assign o_steer_state = r_state;

endmodule
